// File: rtl/excess3_pkg.sv
// Shared constants and FSM state type for the excess-3 word sequencer.
package excess3_pkg;
  localparam int          DIGIT_W   = 4;
  localparam logic [3:0]  E3_OFFSET = 4'd3;
  localparam logic [3:0]  BCD_MAX   = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;
endpackage

// File: rtl/e3_digit_conv.sv
// Combinational 4-bit BCD to excess-3 digit converter, zero latency, no handshake.
// Out-of-range digits still convert mod 16; invalid marks them.
module e3_digit_conv
  import excess3_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [DIGIT_W-1:0] e3,
  output logic               invalid
);

  assign e3      = bcd + E3_OFFSET;
  assign invalid = (bcd > BCD_MAX);

endmodule

// File: rtl/excess3_word_sequencer.sv
// Converts a BCD word to excess-3 one digit per cycle (LSD first) through one shared converter.
// Result valid DIGITS cycles after accept; holds in DONE with frozen outputs while out_ready is low.
module excess3_word_sequencer
  import excess3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_e3,
  output logic [DIGITS-1:0]       out_err,
  output logic                    busy
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  state_t                     state, state_next;
  logic [CNT_W-1:0]           digit_cnt;
  logic [DIGIT_W*DIGITS-1:0]  word;
  logic [DIGIT_W-1:0]         cur_digit;
  logic [DIGIT_W-1:0]         cur_e3;
  logic                       cur_invalid;
  logic                       accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = CONV;
      CONV: if (digit_cnt == LAST_DIGIT) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cur_digit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_cnt == CNT_W'(k)) cur_digit = word[k*DIGIT_W +: DIGIT_W];
    end
  end

  e3_digit_conv u_conv (
    .bcd     (cur_digit),
    .e3      (cur_e3),
    .invalid (cur_invalid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      digit_cnt <= '0;
      word      <= '0;
      out_e3    <= '0;
      out_err   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word      <= in_bcd;
        digit_cnt <= '0;
        out_e3    <= '0;
        out_err   <= '0;
      end else if (state == CONV) begin
        // Counter may step past the last digit on the CONV->DONE edge; it is re-cleared on accept.
        for (int k = 0; k < DIGITS; k++) begin
          if (digit_cnt == CNT_W'(k)) begin
            out_e3[k*DIGIT_W +: DIGIT_W] <= cur_e3;
            out_err[k]                   <= cur_invalid;
          end
        end
        digit_cnt <= digit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_excess3_word_sequencer.sv
// Directed bench for excess3_word_sequencer (DIGITS=4) with an expected-result queue.
module tb_excess3_word_sequencer;

  localparam int DIGITS = 4;

  typedef struct {
    logic [15:0] e3;
    logic [3:0]  err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_e3;
  logic [3:0]  out_err;
  logic        busy;

  int   vectors;
  int   miscompares;
  int   cyc;
  int   last_acc;
  int   acc1;
  exp_t sb[$];

  excess3_word_sequencer #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_e3    (out_e3),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready at a falling edge, presents the word, and
  // returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", in_ready, 1);
    in_valid = 1'b1;
    in_bcd   = w;
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_timeout"}, out_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_e3"},  out_e3,  e.e3);
      chk({tag, "_err"}, out_err, e.err);
      chk({tag, "_latency"}, cyc - last_acc, DIGITS);
    end
  endtask

  task automatic finish_pulse(input string tag);
    @(negedge clk);
    chk({tag, "_valid_one_cycle"}, out_valid, 0);
    chk({tag, "_ready_again"}, in_ready, 1);
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    last_acc    = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_bcd      = '0;
    out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_out_e3",    out_e3,    0);
    chk("rst_out_err",   out_err,   0);

    // Nominal and boundary digit patterns.
    send(16'h1234); sb.push_back('{16'h4567, 4'b0000});
    wait_result("nominal"); finish_pulse("nominal");
    send(16'h9999); sb.push_back('{16'hCCCC, 4'b0000});
    wait_result("nines"); finish_pulse("nines");
    send(16'h0000); sb.push_back('{16'h3333, 4'b0000});
    wait_result("zeros"); finish_pulse("zeros");
    send(16'h0F0A); sb.push_back('{16'h323D, 4'b0101});
    wait_result("invalid_mix"); finish_pulse("invalid_mix");
    send(16'hFEDC); sb.push_back('{16'h210F, 4'b1111});
    wait_result("invalid_all"); finish_pulse("invalid_all");

    // Backpressure: result held, new word ignored until the consumer accepts.
    out_ready = 1'b0;
    send(16'h4321); sb.push_back('{16'h7654, 4'b0000});
    wait_result("bp");
    in_valid = 1'b1;
    in_bcd   = 16'h8888;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid",  out_valid, 1);
      chk("bp_hold_e3",     out_e3,    16'h7654);
      chk("bp_hold_err",    out_err,   0);
      chk("bp_hold_ready",  in_ready,  0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready,  1);
    chk("bp_release_valid", out_valid, 0);
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0;
    chk("bp_new_accept", busy, 1);
    sb.push_back('{16'hBBBB, 4'b0000});
    wait_result("bp_new"); finish_pulse("bp_new");

    // Reset in the middle of a conversion discards the word.
    send(16'h5678);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy",      busy,      0);
    chk("midrst_out_e3",    out_e3,    0);
    chk("midrst_out_err",   out_err,   0);
    send(16'h0001); sb.push_back('{16'h3334, 4'b0000});
    wait_result("after_rst"); finish_pulse("after_rst");

    // Back-to-back words with in_valid held high.
    @(negedge clk);
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_bcd   = 16'h1111;
    @(negedge clk);
    acc1     = cyc;
    last_acc = cyc;
    in_bcd   = 16'h2222;
    sb.push_back('{16'h4444, 4'b0000});
    wait_result("b2b_first");
    finish_pulse("b2b_first");
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    last_acc = cyc;
    in_valid = 1'b0;
    chk("b2b_spacing", last_acc - acc1, DIGITS + 2);
    sb.push_back('{16'h5555, 4'b0000});
    wait_result("b2b_second"); finish_pulse("b2b_second");

    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
